demux_buf: RTL

Registered 1:8 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the team's 8:1 selector. A single input stream of W-bit words, each tagged with a 3-bit channel select, is routed into eight independent one-entry holding registers. Each register drains to its own consumer. The block sits between a shared producer and eight per-channel consumers, and isolates stalls on one channel from the others.

---
 rtl/demux_buf.sv | 134 +++++++++++++
 1 files changed

// File: rtl/demux_buf.sv
// -----------------------------------------------------------------------------
// demux_buf -- registered 1:8 demultiplexer with valid/ready handshakes.
//
// A single producer stream of W-bit words, each tagged with a 3-bit channel
// select, is routed into eight independent one-entry holding registers. Each
// register drains to its own consumer, so a stall on one channel only blocks
// producer beats aimed at that channel and never blocks pops on the others.
//
// Build option:
//   AUTO_SEL_EN  when defined, an internal 3-bit round-robin counter supplies
//                the destination (advancing on every accept, holding on stall)
//                and in_sel is ignored. When undefined, cur_sel = in_sel and
//                no counter is built. The port list is the same in both builds.
//
// Parameters:
//   W          data width per word and per channel (default 4)
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents a word on in_data / in_sel
//   in_ready   block accepts the word this cycle (combinational)
//   in_data    word to route                              [W-1:0]
//   in_sel     destination channel 0..7                   [2:0]
//   out_valid  bit k: channel k holding register is full  [7:0]
//   out_ready  bit k: consumer k takes its word this cycle [7:0]
//   out_data   channel k word on bits [W*k +: W]          [8*W-1:0]
//   cur_sel    effective destination of the current beat  [2:0]
// -----------------------------------------------------------------------------
module demux_buf #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [2:0]     in_sel,
    output logic [7:0]     out_valid,
    input  logic [7:0]     out_ready,
    output logic [8*W-1:0] out_data,
    output logic [2:0]     cur_sel
);

    // Per-channel full flags gathered into one vector for select indexing.
    logic [7:0] full_vec;
    logic       accept;

    // -------------------------------------------------------------------------
    // Effective select
    // -------------------------------------------------------------------------
`ifdef AUTO_SEL_EN
    logic [2:0] sel_cnt_q;
    logic [2:0] sel_cnt_d;
    logic       unused_in_sel;

    // in_sel is deliberately ignored in this build.
    assign unused_in_sel = ^in_sel;

    // Advance only on an accepted beat; a stalled beat keeps pointing at the
    // same channel until that channel drains.
    always_comb begin
        sel_cnt_d = sel_cnt_q;
        if (accept) begin
            sel_cnt_d = sel_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_cnt_q <= 3'd0;
        end else begin
            sel_cnt_q <= sel_cnt_d;
        end
    end

    assign cur_sel = sel_cnt_q;
`else
    assign cur_sel = in_sel;
`endif

    // -------------------------------------------------------------------------
    // Input handshake
    // -------------------------------------------------------------------------
    // A full channel can still take a new word when its consumer pops in the
    // same cycle, which gives back-to-back throughput with one entry per
    // channel. rst_n gates ready so that no beat is accepted while in reset.
    assign in_ready = rst_n & (~full_vec[cur_sel] | out_ready[cur_sel]);
    assign accept   = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // Holding registers, one per channel
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        logic         full_q;
        logic         full_d;
        logic [W-1:0] data_q;
        logic [W-1:0] data_d;
        logic         load;
        logic         pop;

        assign load = accept & (cur_sel == 3'(gi));
        assign pop  = full_q & out_ready[gi];

        // A load wins over a pop: the old word leaves and the new one enters
        // on the same edge, so the flag stays set. On a plain pop the data
        // register keeps its last value; only the flag clears.
        always_comb begin
            full_d = full_q;
            data_d = data_q;
            if (load) begin
                full_d = 1'b1;
                data_d = in_data;
            end else if (pop) begin
                full_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                full_q <= 1'b0;
                data_q <= '0;
            end else begin
                full_q <= full_d;
                data_q <= data_d;
            end
        end

        assign full_vec[gi]        = full_q;
        assign out_valid[gi]       = full_q;
        assign out_data[W*gi +: W] = data_q;
    end

endmodule
